// File: rtl/aposta_tx.sv
// Bet-entry transmitter: accepts a packed BCD ticket over valid/ready and
// serializes it digit by digit onto numero/insere, closing with fim_jogo.
module aposta_tx #(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned GAP        = 1,
  parameter int unsigned MAX_JOGOS  = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ticket_valid,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   ticket,
  output logic                            ticket_ready,
  input  logic                            fim,
  output logic [DIGIT_W-1:0]              numero,
  output logic                            insere,
  output logic                            fim_jogo,
  output logic                            erro,
  output logic [$clog2(MAX_JOGOS+1)-1:0]  jogos_count,
  output logic                            limite
);

  localparam int unsigned TICKET_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_JOGOS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [TICKET_W-1:0]  tkt_q, tkt_d;
  logic [DIGIT_W-1:0]   numero_d;
  logic                 insere_d, fim_jogo_d, erro_d, limite_d;
  logic [CNT_W-1:0]     count_d;
  logic                 last_digit;
  logic [IDX_W-1:0]     idx_inc;

  // Digit k counted from the most significant nibble.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [TICKET_W-1:0] t,
                                                  input logic [IDX_W-1:0]    k);
    logic [TICKET_W-1:0] s;
    s = t >> (DIGIT_W * (NUM_DIGITS - 1 - k));
    return s[DIGIT_W-1:0];
  endfunction

  function automatic logic all_bcd(input logic [TICKET_W-1:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Reset gating keeps ready low while the block is held in reset.
  assign ticket_ready = reset && (state_q == S_IDLE) && !limite;
  assign last_digit   = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign idx_inc      = idx_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tkt_d    = tkt_q;
    numero_d = numero;
    count_d  = jogos_count;

    case (state_q)
      S_IDLE: begin
        if (ticket_valid && ticket_ready) begin
          tkt_d = ticket;
          idx_d = '0;
          if (all_bcd(ticket)) begin
            state_d  = S_SEND;
            numero_d = digit_at(ticket, '0);
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SEND: begin
        if (fim) begin
          state_d = S_IDLE;
        end else if (GAP > 0) begin
          state_d = S_WAIT;
          gap_d   = GAP_W'(GAP - 1);
        end else if (last_digit) begin
          state_d = S_DONE;
        end else begin
          idx_d    = idx_inc;
          numero_d = digit_at(tkt_q, idx_inc);
        end
      end
      S_WAIT: begin
        if (fim) begin
          state_d = S_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (last_digit) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_SEND;
          idx_d    = idx_inc;
          numero_d = digit_at(tkt_q, idx_inc);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered on entry to the state they belong to.
    insere_d   = (state_d == S_SEND);
    fim_jogo_d = (state_d == S_DONE);
    erro_d     = (state_d == S_ERR);
    if (fim_jogo_d && (jogos_count != CNT_W'(MAX_JOGOS))) begin
      count_d = jogos_count + CNT_W'(1);
    end
    limite_d = (count_d == CNT_W'(MAX_JOGOS));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      tkt_q       <= '0;
      numero      <= '0;
      insere      <= 1'b0;
      fim_jogo    <= 1'b0;
      erro        <= 1'b0;
      jogos_count <= '0;
      limite      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tkt_q       <= tkt_d;
      numero      <= numero_d;
      insere      <= insere_d;
      fim_jogo    <= fim_jogo_d;
      erro        <= erro_d;
      jogos_count <= count_d;
      limite      <= limite_d;
    end
  end

endmodule

// File: tb/tb_aposta_tx.sv
// Bench for aposta_tx: one instance with GAP=0 and one with GAP=1 share the
// stimulus; each is checked cycle by cycle against a timing-rule model.
module tb_aposta_tx;

  localparam int N    = 5;
  localparam int MAXJ = 5;
  localparam int WIN  = 14;

  logic        clock = 1'b0;
  logic        reset;
  logic        ticket_valid;
  logic [19:0] ticket;
  logic        fim;

  logic        rdy_s [2];
  logic [3:0]  num_s [2];
  logic        ins_s [2];
  logic        fj_s  [2];
  logic        err_s [2];
  logic [2:0]  cnt_s [2];
  logic        lim_s [2];

  int checks = 0;
  int errors = 0;

  int          cnt_m [2];
  logic [3:0]  num_m [2];

  aposta_tx #(.NUM_DIGITS(5), .DIGIT_W(4), .GAP(0), .MAX_JOGOS(5)) u_dut0 (
    .clock(clock), .reset(reset), .ticket_valid(ticket_valid), .ticket(ticket),
    .ticket_ready(rdy_s[0]), .fim(fim), .numero(num_s[0]), .insere(ins_s[0]),
    .fim_jogo(fj_s[0]), .erro(err_s[0]), .jogos_count(cnt_s[0]), .limite(lim_s[0])
  );

  aposta_tx #(.NUM_DIGITS(5), .DIGIT_W(4), .GAP(1), .MAX_JOGOS(5)) u_dut1 (
    .clock(clock), .reset(reset), .ticket_valid(ticket_valid), .ticket(ticket),
    .ticket_ready(rdy_s[1]), .fim(fim), .numero(num_s[1]), .insere(ins_s[1]),
    .fim_jogo(fj_s[1]), .erro(err_s[1]), .jogos_count(cnt_s[1]), .limite(lim_s[1])
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [19:0] t, input int k);
    logic [19:0] s;
    s = t >> (4 * (N - 1 - k));
    return s[3:0];
  endfunction

  function automatic logic [19:0] rand_ticket();
    logic [19:0] t;
    t = '0;
    for (int k = 0; k < N; k++) t = (t << 4) | 20'($urandom_range(0, 9));
    if ($urandom_range(0, 4) == 0) begin
      int p;
      p = $urandom_range(0, N - 1);
      t[p*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return t;
  endfunction

  // One ticket window of WIN cycles; cycle 0 presents the ticket.
  task automatic run_ticket(input logic [19:0] t, input bit hold, input int abort_at,
                            input int reset_at, input bit noise);
    bit          fimv [WIN];
    bit          bad;
    logic        e_ins [2][WIN];
    logic        e_fj  [2][WIN];
    logic        e_err [2][WIN];
    logic        e_rdy [2][WIN];
    logic [3:0]  e_num [2][WIN];
    int          e_cnt [2][WIN];
    bit          skip  [2][WIN];

    bad = 1'b0;
    for (int k = 0; k < N; k++) if (nib(t, k) > 4'd9) bad = 1'b1;
    for (int c = 0; c < WIN; c++)
      fimv[c] = (c == abort_at) || (noise && $urandom_range(0, 7) == 0);

    for (int d = 0; d < 2; d++) begin
      int   g, f, a, busy_end, cl;
      bit   acc;
      logic [3:0] nm;
      g   = d;
      f   = 1 + N * (g + 1);
      acc = (cnt_m[d] != MAXJ);
      a   = -1;
      if (acc && !bad)
        for (int c = 1; c < f; c++) if (fimv[c] && a < 0) a = c;
      busy_end = !acc ? -1 : bad ? 1 : (a >= 0 ? a : f);
      cl = cnt_m[d];
      nm = num_m[d];
      for (int c = 0; c < WIN; c++) begin
        skip[d][c] = 1'b0;
        if (reset_at >= 0 && c >= reset_at) begin
          e_ins[d][c] = 1'b0;
          e_fj[d][c]  = 1'b0;
          e_err[d][c] = 1'b0;
          e_rdy[d][c] = (c != reset_at);
          cl = 0;
          nm = 4'd0;
        end else begin
          e_ins[d][c] = acc && !bad && c >= 1 && ((c - 1) % (g + 1) == 0)
                        && ((c - 1) / (g + 1) < N) && (a < 0 || c <= a);
          if (e_ins[d][c]) nm = nib(t, (c - 1) / (g + 1));
          e_fj[d][c]  = acc && !bad && a < 0 && c == f;
          if (e_fj[d][c]) begin
            cl++;
            skip[d][c] = 1'b1;
          end
          e_err[d][c] = acc && bad && c == 1;
          e_rdy[d][c] = (c == 0) ? acc : (c > busy_end && cl != MAXJ);
        end
        e_num[d][c] = nm;
        e_cnt[d][c] = cl;
      end
      cnt_m[d] = cl;
      num_m[d] = nm;
    end

    for (int c = 0; c < WIN; c++) begin
      @(negedge clock);
      ticket_valid = (c == 0) || (c == 1 && hold);
      ticket       = (c == 0) ? t : 20'($urandom);
      fim          = fimv[c];
      reset        = (c != reset_at);
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("insere g%0d c%0d", d, c), 32'(ins_s[d]), 32'(e_ins[d][c]));
        check($sformatf("fim_jogo g%0d c%0d", d, c), 32'(fj_s[d]), 32'(e_fj[d][c]));
        check($sformatf("erro g%0d c%0d", d, c), 32'(err_s[d]), 32'(e_err[d][c]));
        check($sformatf("numero g%0d c%0d", d, c), 32'(num_s[d]), 32'(e_num[d][c]));
        check($sformatf("ready g%0d c%0d", d, c), 32'(rdy_s[d]), 32'(e_rdy[d][c]));
        if (!skip[d][c]) begin
          check($sformatf("count g%0d c%0d", d, c), 32'(cnt_s[d]), 32'(e_cnt[d][c]));
          check($sformatf("limite g%0d c%0d", d, c), 32'(lim_s[d]),
                32'(e_cnt[d][c] == MAXJ));
        end
      end
    end
    @(negedge clock);
    ticket_valid = 1'b0;
    fim          = 1'b0;
    reset        = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    ticket_valid = 1'b0;
    ticket       = '0;
    fim          = 1'b0;
    cnt_m        = '{0, 0};
    num_m        = '{4'd0, 4'd0};
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst insere g%0d", d), 32'(ins_s[d]), 32'd0);
      check($sformatf("rst numero g%0d", d), 32'(num_s[d]), 32'd0);
      check($sformatf("rst count g%0d", d), 32'(cnt_s[d]), 32'd0);
      check($sformatf("rst ready g%0d", d), 32'(rdy_s[d]), 32'd0);
      check($sformatf("rst fim_jogo g%0d", d), 32'(fj_s[d] | err_s[d] | lim_s[d]), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    run_ticket(20'h53820, 1'b0, -1, -1, 1'b0);
    run_ticket(20'h5A820, 1'b1, -1, -1, 1'b0);
    run_ticket(20'h53820, 1'b0, 4, -1, 1'b0);
    run_ticket(20'h91407, 1'b1, -1, 6, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_ticket(rand_ticket(), 1'($urandom_range(0, 1)), ab, -1,
                 ($urandom_range(0, 3) == 0));
    end

    run_ticket(20'h12345, 1'b0, -1, 2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      logic [19:0] t;
      t = 20'h0;
      for (int k = 0; k < N; k++) t = (t << 4) | 20'($urandom_range(0, 9));
      run_ticket(t, 1'b1, -1, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
